seg_scan_mux: RTL and testbench

Parametrised time-multiplexed display scanner: cycles round-robin through CHANNELS segment words of WIDTH bits and drives one shared segment bus plus a one-hot channel select. Each channel is held for DWELL clocks, with an optional all-off blanking gap between channels to suppress ghosting. It replaces the clock-selected two-input segment mux that sits between the digit encoders and the display pins.

---
 rtl/seg_scan_pkg.sv | 30 +++
 rtl/seg_scan_if.sv | 31 +++
 rtl/seg_scan_timer.sv | 39 +++
 rtl/seg_scan_mux.sv | 113 +++++++++++
 tb/tb_seg_scan_mux.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and helpers for the segment scan multiplexer
//
// Holds the scan FSM state type, a one-hot decode helper and the
// counter-width helper shared by seg_scan_mux and seg_scan_timer.
package seg_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // One-hot select for channel idx out of n channels; callers cast the
  // result down to their channel count (up to 32 channels supported).
  function automatic logic [31:0] onehot(input int idx, input int n);
    logic [31:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < 32) begin
      v = 32'd1 << idx;
    end
    return v;
  endfunction

  // Bits needed to hold any count in 0..max(dwell, blank).
  function automatic int cnt_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - segment scanner data/display bundle
//
// Ports carried:
//   seg_in      CHANNELS*WIDTH  packed segment words, channel k at [k*WIDTH +: WIDTH]
//   ch_en       CHANNELS        per-channel enable
//   seg_fin     WIDTH           registered segment word on the shared bus
//   ch_sel      CHANNELS        registered one-hot digit select
//   ch_idx      $clog2(CHANNELS) current or upcoming channel index
//   frame_start 1               pulse on the first SHOW cycle of channel 0
// master: word source / display side; slave: the scanner.
interface seg_scan_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12
);
  logic [CHANNELS*WIDTH-1:0]    seg_in;
  logic [CHANNELS-1:0]          ch_en;
  logic [WIDTH-1:0]             seg_fin;
  logic [CHANNELS-1:0]          ch_sel;
  logic [$clog2(CHANNELS)-1:0]  ch_idx;
  logic                         frame_start;

  modport master (
    output seg_in, ch_en,
    input  seg_fin, ch_sel, ch_idx, frame_start
  );

  modport slave (
    input  seg_in, ch_en,
    output seg_fin, ch_sel, ch_idx, frame_start
  );
endinterface

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - loadable up/down counter with terminal-count flag
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset (count -> 0)
//   load_i       load load_val_i this cycle (takes priority over counting)
//   load_val_i   value to load
//   down_i       1 = count down, 0 = count up
//   term_i       terminal value compared against the current count
//   tc_o         high while the count equals term_i
module seg_scan_timer #(
  parameter  int MAX_COUNT = 50000,
  localparam int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          down_i,
  input  logic [CW-1:0] term_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (down_i) begin
      cnt_q <= cnt_q - CW'(1);
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - round-robin time-multiplexed segment display scanner
//
// Shows each of CHANNELS segment words for DWELL clocks on one shared bus
// with a one-hot digit select. With SEG_SCAN_BLANK_EN defined, BLANK clocks
// of all-off output separate consecutive channels; without it the next word
// is loaded directly and BLANK is only a one-cycle state after reset.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset; restarts the scan at channel 0
//   bus   seg_scan_if.slave (seg_in, ch_en in; seg_fin, ch_sel, ch_idx,
//         frame_start out, all outputs registered)
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 12,
  parameter int DWELL    = 50000,
  parameter int BLANK    = 500
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int IW        = $clog2(CHANNELS);
  localparam int MAX_COUNT = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW        = cnt_width(DWELL, BLANK);
`ifdef SEG_SCAN_BLANK_EN
  localparam int BLANK_TERM = BLANK - 1;
`else
  // BLANK state lasts a single cycle (only ever entered from reset).
  localparam int BLANK_TERM = 0;
`endif

  state_t                 state_q;
  logic [IW-1:0]          idx_q;
  logic [WIDTH-1:0]       seg_q;
  logic [CHANNELS-1:0]    sel_q;
  logic                   fs_q;

  logic [WIDTH-1:0]       words [CHANNELS];
  logic [IW-1:0]          nxt_idx_d;
  logic [IW-1:0]          load_idx_d;
  logic [WIDTH-1:0]       load_seg_d;
  logic [CHANNELS-1:0]    load_sel_d;
  logic [CW-1:0]          term;
  logic                   tc;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      words[k] = bus.seg_in[k*WIDTH +: WIDTH];
    end
  end

  assign nxt_idx_d  = (idx_q == IW'(CHANNELS - 1)) ? '0 : idx_q + IW'(1);
  // Leaving BLANK loads the already-advanced idx; a direct SHOW->SHOW
  // reload (no blanking) loads the following channel.
  assign load_idx_d = (state_q == ST_BLANK) ? idx_q : nxt_idx_d;
  assign load_seg_d = bus.ch_en[load_idx_d] ? words[load_idx_d] : '0;
  assign load_sel_d = bus.ch_en[load_idx_d] ?
                      CHANNELS'(onehot(int'(load_idx_d), CHANNELS)) : '0;

  assign term = (state_q == ST_BLANK) ? CW'(BLANK_TERM) : CW'(DWELL - 1);

  // Every state transition restarts the count from zero.
  seg_scan_timer #(.MAX_COUNT(MAX_COUNT)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tc),
    .load_val_i ('0),
    .down_i     (1'b0),
    .term_i     (term),
    .tc_o       (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BLANK;
      idx_q   <= '0;
      seg_q   <= '0;
      sel_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      if (tc) begin
        if (state_q == ST_BLANK) begin
          state_q <= ST_SHOW;
          seg_q   <= load_seg_d;
          sel_q   <= load_sel_d;
          fs_q    <= (load_idx_d == '0);
        end else begin
`ifdef SEG_SCAN_BLANK_EN
          state_q <= ST_BLANK;
          seg_q   <= '0;
          sel_q   <= '0;
          idx_q   <= nxt_idx_d;
`else
          idx_q   <= nxt_idx_d;
          seg_q   <= load_seg_d;
          sel_q   <= load_sel_d;
          fs_q    <= (load_idx_d == '0);
`endif
        end
      end
    end
  end

  assign bus.seg_fin     = seg_q;
  assign bus.ch_sel      = sel_q;
  assign bus.ch_idx      = idx_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - scoreboard testbench for seg_scan_mux
module tb_seg_scan_mux;

  localparam int CH = 4;
  localparam int W  = 12;
`ifdef SEG_SCAN_BLANK_EN
  localparam int LEAD = 2;   // edges from reset release to first shown word
  localparam int SLOT = 6;   // DWELL + BLANK
`else
  localparam int LEAD = 1;
  localparam int SLOT = 4;   // DWELL
`endif

  typedef struct {
    logic [11:0] seg;
    logic [3:0]  sel;
    logic [1:0]  idx;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] words [4];
  logic [3:0]  en;
  exp_t        exp_q [$];
  int          t;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [11:0] lat_seg;
  logic [3:0]  lat_sel;
  int          cyc = 0;
  int          last_fs = -1;

  always #5 clk = ~clk;

  seg_scan_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  assign bus.seg_in = {words[3], words[2], words[1], words[0]};
  assign bus.ch_en  = en;

  seg_scan_mux #(.CHANNELS(CH), .WIDTH(W), .DWELL(4), .BLANK(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int start(input int f, input int c);
    return LEAD + (f * 4 + c) * SLOT;
  endfunction

  // Advance one clock: predict outputs after the coming edge, queue them.
  task automatic step();
    exp_t e;
    int u, ph, ch;
    t++;
    e.seg = '0; e.sel = '0; e.idx = '0; e.fs = 1'b0;
    if (t >= LEAD) begin
      u  = t - LEAD;
      ph = u % SLOT;
      ch = (u / SLOT) % 4;
      if (ph == 0) begin
        lat_seg = en[ch] ? words[ch] : 12'h000;
        lat_sel = en[ch] ? 4'(1 << ch) : 4'h0;
      end
      if (ph < 4) begin
        e.seg = lat_seg;
        e.sel = lat_sel;
        e.fs  = (ph == 0 && ch == 0);
        e.idx = 2'(ch);
      end else begin
        e.idx = 2'((ch + 1) % 4);
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_seg"}, 32'(bus.seg_fin), 32'h0);
    check({tag, "_sel"}, 32'(bus.ch_sel), 32'h0);
    check({tag, "_idx"}, 32'(bus.ch_idx), 32'h0);
    check({tag, "_fs"},  32'(bus.frame_start), 32'h0);
  endtask

  // Monitor: compare against the scoreboard after every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seg_fin",     32'(bus.seg_fin),     32'(e.seg));
      check("ch_sel",      32'(bus.ch_sel),      32'(e.sel));
      check("ch_idx",      32'(bus.ch_idx),      32'(e.idx));
      check("frame_start", 32'(bus.frame_start), 32'(e.fs));
    end
    if (rst) begin
      last_fs = -1;
    end else if (bus.frame_start) begin
      if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'(4 * SLOT));
      last_fs = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    words[0] = 12'h0A1; words[1] = 12'h0B2; words[2] = 12'h0C3; words[3] = 12'h0D4;
    en = 4'b1111;
    lat_seg = '0; lat_sel = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    t = 0;

    run_to(LEAD);
    check("first_seg", 32'(bus.seg_fin), 32'h0A1);
    check("first_sel", 32'(bus.ch_sel), 32'h1);
    check("first_fs",  32'(bus.frame_start), 32'h1);

    // Frame 1: channel 2 disabled for its slot.
    run_to(start(1, 0) - 1);
    en = 4'b1011;
    run_to(start(1, 2));
    check("dis_seg", 32'(bus.seg_fin), 32'h0);
    check("dis_sel", 32'(bus.ch_sel), 32'h0);
    check("dis_idx", 32'(bus.ch_idx), 32'h2);
    run_to(start(1, 3) - 1);
    en = 4'b1111;

    // Frame 2: change ch1 word during its 2nd SHOW cycle.
    run_to(start(2, 1) + 1);
    words[1] = 12'hFFF;
    run_to(start(2, 1) + 3);
    check("hold_seg", 32'(bus.seg_fin), 32'h0B2);
    run_to(start(3, 1));
    check("new_seg", 32'(bus.seg_fin), 32'hFFF);
    check("new_sel", 32'(bus.ch_sel), 32'h2);

    // Asynchronous reset mid-SHOW of channel 2.
    run_to(start(3, 2) + 1);
    check("pre_rst_sel", 32'(bus.ch_sel), 32'h4);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    begin
      exp_t z;
      z.seg = '0; z.sel = '0; z.idx = '0; z.fs = 1'b0;
      exp_q.push_back(z);
    end
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    run_to(LEAD);
    check("restart_seg", 32'(bus.seg_fin), 32'h0A1);
    check("restart_sel", 32'(bus.ch_sel), 32'h1);
    run_to(start(1, 0) + 2);

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
